// File: rtl/alu_issue_pkg.sv
// Shared ISA constants and ALU request codes for the decode-side issuer
// and the EX-side ALU control decoder.
package alu_issue_pkg;

    // Opcodes understood by the issuer
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type func codes consumed by the ALU control decoder
    localparam logic [5:0] FUNC_ADD = 6'b100000;
    localparam logic [5:0] FUNC_SUB = 6'b100010;
    localparam logic [5:0] FUNC_AND = 6'b100100;
    localparam logic [5:0] FUNC_OR  = 6'b100101;
    localparam logic [5:0] FUNC_SLT = 6'b101010;

    // 2-bit ALU request codes
    localparam logic [1:0] INOP_PUSH_ADD   = 2'd0;
    localparam logic [1:0] INOP_PUSH_SUB   = 2'd1;
    localparam logic [1:0] INOP_DIAGNOSTIC = 2'd2;
    localparam logic [1:0] INOP_NOP        = 2'd3;

    // ID/EX pipeline register content
    typedef struct packed {
        logic [1:0] inop;
        logic [5:0] func;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src;
        logic       valid;
    } idex_t;

    // Bubble: nop request, everything else cleared
    function automatic idex_t idex_bubble();
        idex_t b;
        b      = '0;
        b.inop = INOP_NOP;
        return b;
    endfunction

endpackage

// File: rtl/alu_issue_stage_decode.sv
// issue_decode: pure combinational opcode -> ALU request + control bits.
module issue_decode
    import alu_issue_pkg::*;
(
    input  logic [5:0] opcode,
    output logic [1:0] inop,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       alu_src,
    output logic       uses_rt
);

    // Opcode decode; j and undefined opcodes fall to nop with no control
    always_comb begin
        inop      = INOP_NOP;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        reg_dst   = 1'b0;
        alu_src   = 1'b0;
        uses_rt   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                inop      = INOP_DIAGNOSTIC;
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                uses_rt   = 1'b1;
            end
            OP_LW: begin
                inop      = INOP_PUSH_ADD;
                mem_read  = 1'b1;
                reg_write = 1'b1;
                alu_src   = 1'b1;
            end
            OP_SW: begin
                inop      = INOP_PUSH_ADD;
                mem_write = 1'b1;
                alu_src   = 1'b1;
                uses_rt   = 1'b1;
            end
            OP_ADDI: begin
                inop      = INOP_PUSH_ADD;
                reg_write = 1'b1;
                alu_src   = 1'b1;
            end
            OP_BEQ: begin
                inop      = INOP_PUSH_SUB;
                uses_rt   = 1'b1;
            end
            OP_J:    inop = INOP_NOP;
            default: inop = INOP_NOP;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX register with load-use hazard bubbles, branch
// flush, downstream hold and a saturating bubble counter.
module alu_issue_stage
    import alu_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  id_opcode,
    input  logic [5:0]  id_func,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic        id_valid,
    input  logic        flush,
    input  logic        hold,
    output logic        stall,
    output logic [1:0]  ex_inop,
    output logic [5:0]  ex_func,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_rd,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_reg_write,
    output logic        ex_reg_dst,
    output logic        ex_alu_src,
    output logic        ex_valid,
    output logic [15:0] bubble_count
);

    idex_t      idex_q;
    idex_t      idex_d;
    logic [1:0] dec_inop;
    logic       dec_mem_read;
    logic       dec_mem_write;
    logic       dec_reg_write;
    logic       dec_reg_dst;
    logic       dec_alu_src;
    logic       dec_uses_rt;
    logic       hz;

    issue_decode u_decode (
        .opcode    (id_opcode),
        .inop      (dec_inop),
        .mem_read  (dec_mem_read),
        .mem_write (dec_mem_write),
        .reg_write (dec_reg_write),
        .reg_dst   (dec_reg_dst),
        .alu_src   (dec_alu_src),
        .uses_rt   (dec_uses_rt)
    );

    // Load in EX whose destination feeds the ID instruction; r0 never hazards
    always_comb begin
        hz = idex_q.valid & idex_q.mem_read & id_valid & (idex_q.rt != 5'd0) &
             ((idex_q.rt == id_rs) | ((idex_q.rt == id_rt) & dec_uses_rt));
    end

    // IF/ID and PC freeze; a flush squashes ID so nothing needs holding
    assign stall = (hz | hold) & ~flush;

    // Decoded ID instruction as it would enter ID/EX; invalid ID becomes a bubble
    always_comb begin
        idex_d = idex_bubble();
        if (id_valid) begin
            idex_d.inop      = dec_inop;
            idex_d.func      = id_func;
            idex_d.rs        = id_rs;
            idex_d.rt        = id_rt;
            idex_d.rd        = id_rd;
            idex_d.mem_read  = dec_mem_read;
            idex_d.mem_write = dec_mem_write;
            idex_d.reg_write = dec_reg_write;
            idex_d.reg_dst   = dec_reg_dst;
            idex_d.alu_src   = dec_alu_src;
            idex_d.valid     = 1'b1;
        end
    end

    // ID/EX register and bubble counter: rst > flush > hold > hazard > load
    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q       <= idex_bubble();
            bubble_count <= 16'd0;
        end else if (flush) begin
            idex_q <= idex_bubble();
        end else if (hold) begin
            idex_q <= idex_q;
        end else if (hz) begin
            idex_q <= idex_bubble();
            if (bubble_count != 16'hFFFF)
                bubble_count <= bubble_count + 16'd1;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign ex_inop      = idex_q.inop;
    assign ex_func      = idex_q.func;
    assign ex_rs        = idex_q.rs;
    assign ex_rt        = idex_q.rt;
    assign ex_rd        = idex_q.rd;
    assign ex_mem_read  = idex_q.mem_read;
    assign ex_mem_write = idex_q.mem_write;
    assign ex_reg_write = idex_q.reg_write;
    assign ex_reg_dst   = idex_q.reg_dst;
    assign ex_alu_src   = idex_q.alu_src;
    assign ex_valid     = idex_q.valid;

endmodule
